// File: rtl/cc_micro_sequencer_if.sv
// Bus between the ARC control unit (master) and its microsequencer (slave).
// Master drives the MIR fields, decode address, %psr flags, IR[13] and stall;
// slave returns the registered control-store address, taken flag, stack depth
// and the sticky overflow/underflow flags.
interface cc_micro_sequencer_if #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned COND_WIDTH  = 4,
  parameter int unsigned FLAG_WIDTH  = 4,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned DepthWidth = $clog2(STACK_DEPTH + 1);

  logic [COND_WIDTH-1:0] Seq_Condition;
  logic [ADDR_WIDTH-1:0] Seq_JumpAddr;
  logic [ADDR_WIDTH-1:0] Seq_DecodeAddr;
  logic [FLAG_WIDTH-1:0] Seq_Flags;
  logic                  Seq_Ir13;
  logic                  Seq_Stall;
  logic [ADDR_WIDTH-1:0] Seq_Addr;
  logic                  Seq_Taken;
  logic [DepthWidth-1:0] Seq_Depth;
  logic                  Seq_Overflow;
  logic                  Seq_Underflow;

  modport master (
    output Seq_Condition, Seq_JumpAddr, Seq_DecodeAddr, Seq_Flags, Seq_Ir13, Seq_Stall,
    input  Seq_Addr, Seq_Taken, Seq_Depth, Seq_Overflow, Seq_Underflow
  );

  modport slave (
    input  Seq_Condition, Seq_JumpAddr, Seq_DecodeAddr, Seq_Flags, Seq_Ir13, Seq_Stall,
    output Seq_Addr, Seq_Taken, Seq_Depth, Seq_Overflow, Seq_Underflow
  );
endinterface

// File: rtl/cc_micro_sequencer.sv
// Microsequencer for the ARC control unit. Owns the control-store address
// register, evaluates the MIR COND field against %psr flags and IR[13], and
// provides microsubroutine CALL/RET through a return-address stack.
// Ports:
//   Seq_CLOCK_50    system clock, rising edge
//   Seq_RESET_InLow asynchronous reset, active low
//   bus (slave)     COND/JUMP/DECODE/flags/IR13/stall in; address, taken,
//                   stack depth, sticky overflow/underflow out (all registered)
module cc_micro_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned COND_WIDTH  = 4,
  parameter int unsigned FLAG_WIDTH  = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                Seq_CLOCK_50,
  input  logic                Seq_RESET_InLow,
  cc_micro_sequencer_if.slave bus
);

  localparam int unsigned DepthWidth = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxWidth   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    CondNext   = 4'h0,
    CondN      = 4'h1,
    CondZ      = 4'h2,
    CondV      = 4'h3,
    CondC      = 4'h4,
    CondIr13   = 4'h5,
    CondJump   = 4'h6,
    CondDecode = 4'h7,
    CondCall   = 4'h8,
    CondRet    = 4'h9,
    CondNotN   = 4'hA,
    CondNotZ   = 4'hB,
    CondNotV   = 4'hC,
    CondNotC   = 4'hD,
    CondNIr13  = 4'hE,
    CondRsvd   = 4'hF
  } cond_e;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  taken_q, taken_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  push_en;
  logic [IdxWidth-1:0]   push_idx;
  logic [IdxWidth-1:0]   pop_idx;
  logic                  cond_in_range;
  cond_e                 cond_op;
  logic                  flag_n, flag_z, flag_v, flag_c;
  logic                  stack_full, stack_empty;

  assign flag_n = bus.Seq_Flags[FLAG_WIDTH-1];
  assign flag_z = bus.Seq_Flags[FLAG_WIDTH-2];
  assign flag_v = bus.Seq_Flags[FLAG_WIDTH-3];
  assign flag_c = bus.Seq_Flags[FLAG_WIDTH-4];

  // Codes beyond the 4-bit encoding (wider COND fields) behave as reserved.
  assign cond_in_range = ((bus.Seq_Condition >> 4) == '0);
  assign cond_op       = cond_in_range ? cond_e'(bus.Seq_Condition[3:0]) : CondRsvd;

  assign addr_inc    = addr_q + ADDR_WIDTH'(1);
  assign stack_full  = (depth_q == DepthWidth'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign push_idx    = IdxWidth'(depth_q);
  assign pop_idx     = IdxWidth'(depth_q - DepthWidth'(1));

  always_comb begin
    addr_d  = addr_inc;
    taken_d = 1'b0;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    if (bus.Seq_Stall) begin
      addr_d  = addr_q;
      taken_d = taken_q;
    end else begin
      unique case (cond_op)
        CondNext, CondRsvd: ;
        CondN:     if (flag_n)        begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondZ:     if (flag_z)        begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondV:     if (flag_v)        begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondC:     if (flag_c)        begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondIr13:  if (bus.Seq_Ir13)  begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondNotN:  if (!flag_n)       begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondNotZ:  if (!flag_z)       begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondNotV:  if (!flag_v)       begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondNotC:  if (!flag_c)       begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondNIr13: if (!bus.Seq_Ir13) begin addr_d = bus.Seq_JumpAddr; taken_d = 1'b1; end
        CondJump: begin
          addr_d  = bus.Seq_JumpAddr;
          taken_d = 1'b1;
        end
        CondDecode: begin
          addr_d  = bus.Seq_DecodeAddr;
          taken_d = 1'b1;
        end
        CondCall: begin
          // A full stack turns CALL into a plain increment so the return
          // chain already on the stack stays intact.
          if (stack_full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DepthWidth'(1);
            addr_d  = bus.Seq_JumpAddr;
            taken_d = 1'b1;
          end
        end
        CondRet: begin
          taken_d = 1'b1;
          if (stack_empty) begin
            addr_d = '0;
            unf_d  = 1'b1;
          end else begin
            depth_d = depth_q - DepthWidth'(1);
            addr_d  = stack_q[pop_idx];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Seq_CLOCK_50 or negedge Seq_RESET_InLow) begin
    if (!Seq_RESET_InLow) begin
      addr_q  <= '0;
      taken_q <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      taken_q <= taken_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents need no reset: depth_q alone decides which entries are live,
  // so a write landing while reset is held is never observed.
  always_ff @(posedge Seq_CLOCK_50) begin
    if (push_en) begin
      stack_q[push_idx] <= addr_inc;
    end
  end

  assign bus.Seq_Addr      = addr_q;
  assign bus.Seq_Taken     = taken_q;
  assign bus.Seq_Depth     = depth_q;
  assign bus.Seq_Overflow  = ovf_q;
  assign bus.Seq_Underflow = unf_q;

endmodule

// File: tb/tb_cc_micro_sequencer.sv
module tb_cc_micro_sequencer;

  localparam int unsigned AW = 11;
  localparam int unsigned SD = 4;
  localparam int         AddrMod = 1 << AW;

  logic clk;
  logic rst_n;

  cc_micro_sequencer_if #(
    .ADDR_WIDTH (AW),
    .COND_WIDTH (4),
    .FLAG_WIDTH (4),
    .STACK_DEPTH(SD)
  ) bus ();

  cc_micro_sequencer #(
    .ADDR_WIDTH (AW),
    .COND_WIDTH (4),
    .FLAG_WIDTH (4),
    .STACK_DEPTH(SD)
  ) dut (
    .Seq_CLOCK_50   (clk),
    .Seq_RESET_InLow(rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: the stack is a plain queue of return addresses.
  int m_addr;
  bit m_taken;
  bit m_ovf;
  bit m_unf;
  int m_stack[$];

  typedef struct {
    logic [3:0]    cond;
    logic [AW-1:0] jump;
    logic [AW-1:0] dec;
    logic [3:0]    flags;
    logic          ir13;
    logic          stall;
    int            exp_addr;
    int            exp_taken;
    int            exp_depth;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cond, input logic [AW-1:0] jump,
                       input logic [AW-1:0] dec, input logic [3:0] flags,
                       input logic ir13, input logic stall);
    bus.Seq_Condition  = cond;
    bus.Seq_JumpAddr   = jump;
    bus.Seq_DecodeAddr = dec;
    bus.Seq_Flags      = flags;
    bus.Seq_Ir13       = ir13;
    bus.Seq_Stall      = stall;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    m_addr  = 0;
    m_taken = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stack.delete();
  endtask

  task automatic check_out(input string tag, input int addr, input int taken, input int depth,
                           input int ovf, input int unf);
    check({tag, ".addr"},  int'(bus.Seq_Addr),      addr);
    check({tag, ".taken"}, int'(bus.Seq_Taken),     taken);
    check({tag, ".depth"}, int'(bus.Seq_Depth),     depth);
    check({tag, ".ovf"},   int'(bus.Seq_Overflow),  ovf);
    check({tag, ".unf"},   int'(bus.Seq_Underflow), unf);
  endtask

  // Behaviour of one clock edge, expressed directly from the COND table.
  task automatic model_step(input int cond, input int jump, input int dec, input int flags,
                            input bit ir13, input bit stall);
    int inc;
    bit hit;
    if (stall) return;
    inc     = (m_addr + 1) % AddrMod;
    hit     = 0;
    m_taken = 0;
    if (cond >= 1 && cond <= 4)        hit = flags[4 - cond] == 1;
    else if (cond >= 10 && cond <= 13) hit = flags[13 - cond] == 0;
    else if (cond == 5)                hit = ir13;
    else if (cond == 14)               hit = !ir13;
    else if (cond == 6)                hit = 1;
    if (hit) begin
      m_addr  = jump;
      m_taken = 1;
    end else if (cond == 7) begin
      m_addr  = dec;
      m_taken = 1;
    end else if (cond == 8) begin
      if (m_stack.size() == SD) begin
        m_ovf  = 1;
        m_addr = inc;
      end else begin
        m_stack.push_back(inc);
        m_addr  = jump;
        m_taken = 1;
      end
    end else if (cond == 9) begin
      m_taken = 1;
      if (m_stack.size() == 0) begin
        m_unf  = 1;
        m_addr = 0;
      end else begin
        m_addr = m_stack.pop_back();
      end
    end else begin
      m_addr = inc;
    end
  endtask

  initial begin
    // cond, jump, decode, flags, ir13, stall, addr, taken, depth
    vecs[0]  = '{4'h0, 11'h000, 11'h000, 4'b0000, 1'b0, 1'b0, 'h001, 0, 0};
    vecs[1]  = '{4'h0, 11'h000, 11'h000, 4'b0000, 1'b0, 1'b0, 'h002, 0, 0};
    vecs[2]  = '{4'h0, 11'h000, 11'h000, 4'b0000, 1'b0, 1'b0, 'h003, 0, 0};
    vecs[3]  = '{4'h6, 11'h005, 11'h000, 4'b0000, 1'b0, 1'b0, 'h005, 1, 0};
    vecs[4]  = '{4'h2, 11'h040, 11'h000, 4'b0100, 1'b0, 1'b0, 'h040, 1, 0};
    vecs[5]  = '{4'h6, 11'h005, 11'h000, 4'b0000, 1'b0, 1'b0, 'h005, 1, 0};
    vecs[6]  = '{4'h2, 11'h040, 11'h000, 4'b0000, 1'b0, 1'b0, 'h006, 0, 0};
    vecs[7]  = '{4'hB, 11'h040, 11'h000, 4'b0000, 1'b0, 1'b0, 'h040, 1, 0};
    vecs[8]  = '{4'h5, 11'h123, 11'h000, 4'b0000, 1'b1, 1'b0, 'h123, 1, 0};
    vecs[9]  = '{4'hE, 11'h300, 11'h000, 4'b0000, 1'b1, 1'b0, 'h124, 0, 0};
    vecs[10] = '{4'h1, 11'h7FF, 11'h000, 4'b1000, 1'b0, 1'b0, 'h7FF, 1, 0};
    vecs[11] = '{4'h0, 11'h000, 11'h000, 4'b0000, 1'b0, 1'b0, 'h000, 0, 0};
    vecs[12] = '{4'h7, 11'h000, 11'h4A0, 4'b0000, 1'b0, 1'b0, 'h4A0, 1, 0};
    vecs[13] = '{4'hF, 11'h010, 11'h000, 4'b0000, 1'b0, 1'b0, 'h4A1, 0, 0};
    vecs[14] = '{4'h6, 11'h010, 11'h000, 4'b0000, 1'b0, 1'b1, 'h4A1, 0, 0};
    vecs[15] = '{4'h6, 11'h010, 11'h000, 4'b0000, 1'b0, 1'b0, 'h010, 1, 0};
    vecs[16] = '{4'h8, 11'h200, 11'h000, 4'b0000, 1'b0, 1'b0, 'h200, 1, 1};
    vecs[17] = '{4'h9, 11'h000, 11'h000, 4'b0000, 1'b0, 1'b0, 'h011, 1, 0};
    vecs[18] = '{4'hD, 11'h055, 11'h000, 4'b0001, 1'b0, 1'b0, 'h012, 0, 0};
    vecs[19] = '{4'hC, 11'h055, 11'h000, 4'b0001, 1'b0, 1'b0, 'h055, 1, 0};

    rst_n = 1'b1;
    drive(4'h0, '0, '0, 4'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].cond, vecs[i].jump, vecs[i].dec, vecs[i].flags, vecs[i].ir13,
            vecs[i].stall);
      tick();
      check($sformatf("vec%0d.addr", i),  int'(bus.Seq_Addr),  vecs[i].exp_addr);
      check($sformatf("vec%0d.taken", i), int'(bus.Seq_Taken), vecs[i].exp_taken);
      check($sformatf("vec%0d.depth", i), int'(bus.Seq_Depth), vecs[i].exp_depth);
    end

    // Nested CALLs past the stack limit, then RETs past empty.
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(4'h8, AW'(i * 'h100), '0, 4'h0, 1'b0, 1'b0);
      tick();
      check_out($sformatf("call%0d", i), i * 'h100, 1, i, 0, 0);
    end
    drive(4'h8, 11'h500, '0, 4'h0, 1'b0, 1'b0);
    tick();
    check_out("call5_full", 'h401, 0, 4, 1, 0);
    for (int i = 3; i >= 0; i--) begin
      drive(4'h9, '0, '0, 4'h0, 1'b0, 1'b0);
      tick();
      check_out($sformatf("ret_d%0d", i), i * 'h100 + 1, 1, i, 1, 0);
    end
    drive(4'h9, '0, '0, 4'h0, 1'b0, 1'b0);
    tick();
    check_out("ret_empty", 0, 1, 0, 1, 1);

    // Stalled CALL holds everything; reset landing during a CALL wins.
    apply_reset();
    drive(4'h0, '0, '0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_out("pre_stall", 2, 0, 0, 0, 0);
    drive(4'h8, 11'h3C0, '0, 4'h0, 1'b0, 1'b1);
    tick();
    check_out("stall1", 2, 0, 0, 0, 0);
    tick();
    check_out("stall2", 2, 0, 0, 0, 0);
    drive(4'h8, 11'h3C0, '0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("rst_call_async", 0, 0, 0, 0, 0);
    tick();
    check_out("rst_call_edge", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised run against the reference model, reset between segments.
    for (int seg = 0; seg < 4; seg++) begin
      apply_reset();
      for (int n = 0; n < 500; n++) begin
        int  cond;
        int  jump;
        int  dec;
        int  flags;
        bit  ir13;
        bit  stall;
        cond  = (seg == 0) ? int'($urandom_range(8, 9)) : int'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) cond = int'($urandom_range(8, 9));
        jump  = int'($urandom_range(0, AddrMod - 1));
        if ($urandom_range(0, 7) == 0) jump = AddrMod - 1;
        dec   = int'($urandom_range(0, AddrMod - 1));
        flags = int'($urandom_range(0, 15));
        ir13  = 1'($urandom_range(0, 1));
        stall = ($urandom_range(0, 7) == 0);
        drive(4'(cond), AW'(jump), AW'(dec), 4'(flags), ir13, stall);
        model_step(cond, jump, dec, flags, ir13, stall);
        tick();
        check_out($sformatf("rnd%0d_%0d", seg, n), m_addr, int'(m_taken), m_stack.size(),
                  int'(m_ovf), int'(m_unf));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
